// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: EX operand register feeding the ALU, EX/MEM result
// register, and the architectural condition-code register with its interrupt shadow.
module alu_exec_ctrl #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [3:0]   in_op,
    input  logic [N-1:0] in_src,
    input  logic [N-1:0] in_dst,
    input  logic         stall,
    input  logic         flush,
    input  logic [2:0]   flag_clr,
    input  logic         int_save,
    input  logic         rti_restore,
    output logic [3:0]   alu_ctrl,
    output logic [N-1:0] alu_src,
    output logic [N-1:0] alu_dst,
    input  logic [N-1:0] alu_out,
    input  logic         alu_c,
    input  logic         alu_z,
    input  logic         alu_n,
    output logic         out_valid,
    output logic [N-1:0] out_result,
    output logic [3:0]   out_op,
    output logic [2:0]   ccr
);

    localparam logic [3:0] OP_NOT  = 4'd1;
    localparam logic [3:0] OP_INC  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_SETC = 4'd11;
    localparam logic [3:0] OP_CLRC = 4'd12;

    logic         ex_valid;
    logic [3:0]   ex_op;
    logic [N-1:0] ex_src;
    logic [N-1:0] ex_dst;
    logic [2:0]   shadow;
    logic [2:0]   ccr_next;
    logic         commit;
    logic         flag_op;

    assign commit   = ex_valid && !stall && !flush;
    assign flag_op  = (ex_op inside {[OP_NOT:OP_DEC], [OP_ADD:OP_CLRC]});

    assign alu_ctrl = ex_valid ? ex_op : 4'd0;
    assign alu_src  = ex_src;
    assign alu_dst  = ex_dst;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_op    <= 4'd0;
            ex_src   <= '0;
            ex_dst   <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (!stall) begin
            ex_valid <= in_valid;
            ex_op    <= in_op;
            ex_src   <= in_src;
            ex_dst   <= in_dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_op     <= 4'd0;
        end else if (commit) begin
            out_valid  <= 1'b1;
            out_result <= alu_out;
            out_op     <= ex_op;
        end else begin
            out_valid  <= 1'b0;
        end
    end

    // Restore beats the commit update, and a jump clear beats any set from it.
    always_comb begin
        // NOTE: default first so every path assigns ccr_next and no latch is inferred.
        ccr_next = ccr;
        if (commit && flag_op) begin
            ccr_next[1] = alu_n;
            ccr_next[0] = alu_z;
            case (ex_op)
                OP_SETC:                        ccr_next[2] = 1'b1;
                OP_CLRC, OP_NOT, OP_AND, OP_OR: ccr_next[2] = 1'b0;
                default:                        ccr_next[2] = alu_c;
            endcase
        end
        ccr_next = ccr_next & ~flag_clr;
        if (rti_restore) begin
            ccr_next = shadow;
        end
    end

    // Shadow captures the pre-update CCR, so save+restore on one edge swaps them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccr    <= 3'b000;
            shadow <= 3'b000;
        end else begin
            ccr <= ccr_next;
            if (int_save) begin
                shadow <= ccr;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: directed vectors push hand-computed
// {result, op, ccr} expectations; a monitor pops one per out_valid cycle.
module tb_alu_exec_ctrl;

    localparam int N = 16;

    typedef struct packed {
        logic [N-1:0] res;
        logic [3:0]   op;
        logic [2:0]   ccr;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [3:0]   in_op;
    logic [N-1:0] in_src;
    logic [N-1:0] in_dst;
    logic         stall;
    logic         flush;
    logic [2:0]   flag_clr;
    logic         int_save;
    logic         rti_restore;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] alu_src;
    logic [N-1:0] alu_dst;
    logic [N-1:0] alu_out;
    logic         alu_c;
    logic         alu_z;
    logic         alu_n;
    logic         out_valid;
    logic [N-1:0] out_result;
    logic [3:0]   out_op;
    logic [2:0]   ccr;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_exec_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_op      (in_op),
        .in_src     (in_src),
        .in_dst     (in_dst),
        .stall      (stall),
        .flush      (flush),
        .flag_clr   (flag_clr),
        .int_save   (int_save),
        .rti_restore(rti_restore),
        .alu_ctrl   (alu_ctrl),
        .alu_src    (alu_src),
        .alu_dst    (alu_dst),
        .alu_out    (alu_out),
        .alu_c      (alu_c),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_op     (out_op),
        .ccr        (ccr)
    );

    // Behavioural ALU. Logic ops drive carry high so the controller's forced C=0 is observable;
    // nop/SETC/CLRC present the held previous result.
    logic [N-1:0] alu_held = '0;
    logic [N-1:0] m_res;
    logic         m_c;
    logic [N:0]   wide;

    always_comb begin
        wide  = '0;
        m_c   = 1'b0;
        m_res = alu_held;
        case (alu_ctrl)
            4'd1: begin m_res = ~alu_src; m_c = 1'b1; end
            4'd2: begin wide = {1'b0, alu_src} + 17'd1; m_res = wide[N-1:0]; m_c = wide[N]; end
            4'd3: begin m_res = alu_src - 16'd1; m_c = (alu_src == 16'd0); end
            4'd4, 4'd9, 4'd10, 4'd13, 4'd14: m_res = alu_src;
            4'd5: begin wide = {1'b0, alu_src} + {1'b0, alu_dst}; m_res = wide[N-1:0]; m_c = wide[N]; end
            4'd6: begin m_res = alu_src - alu_dst; m_c = (alu_src < alu_dst); end
            4'd7: begin m_res = alu_src & alu_dst; m_c = 1'b1; end
            4'd8: begin m_res = alu_src | alu_dst; m_c = 1'b1; end
            default: ;
        endcase
    end

    assign alu_out = m_res;
    assign alu_c   = m_c;
    assign alu_z   = (m_res == '0);
    assign alu_n   = m_res[N-1];

    always @(posedge clk) begin
        if (!(alu_ctrl inside {4'd0, 4'd11, 4'd12})) begin
            alu_held <= alu_out;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_result", {16'd0, out_result}, {16'd0, e.res});
                check("sb_op",     {28'd0, out_op},     {28'd0, e.op});
                check("sb_ccr",    {29'd0, ccr},        {29'd0, e.ccr});
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] op, input logic [N-1:0] src, input logic [N-1:0] dst);
        in_valid = 1'b1;
        in_op    = op;
        in_src   = src;
        in_dst   = dst;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_op    = 4'd0;
        in_src   = '0;
        in_dst   = '0;
    endtask

    task automatic expect_out(input logic [N-1:0] res, input logic [3:0] op, input logic [2:0] c);
        sb_q.push_back('{res: res, op: op, ccr: c});
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"},  {31'd0, out_valid},  32'd0);
        check({tag, "_out_result"}, {16'd0, out_result}, 32'd0);
        check({tag, "_out_op"},     {28'd0, out_op},     32'd0);
        check({tag, "_ccr"},        {29'd0, ccr},        32'd0);
        check({tag, "_alu_ctrl"},   {28'd0, alu_ctrl},   32'd0);
        check({tag, "_alu_src"},    {16'd0, alu_src},    32'd0);
        check({tag, "_alu_dst"},    {16'd0, alu_dst},    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        idle();
        stall = 1'b0; flush = 1'b0; flag_clr = 3'b000;
        int_save = 1'b0; rti_restore = 1'b0;
        #1 rst_n = 1'b0;
        step();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        step();

        // ADD 0xFFFF + 0x0001 -> 0x0000, C=1 Z=1, then a bubble.
        issue(4'd5, 16'hFFFF, 16'h0001); expect_out(16'h0000, 4'd5, 3'b101);
        step(); idle();
        step(); check("add_valid", {31'd0, out_valid}, 32'd1);
        step(); check("add_bubble", {31'd0, out_valid}, 32'd0);

        // Back-to-back SUB then AND on consecutive cycles.
        issue(4'd6, 16'h0005, 16'h0007); expect_out(16'hFFFE, 4'd6, 3'b110);
        step();
        issue(4'd7, 16'h00F0, 16'h0F0F); expect_out(16'h0000, 4'd7, 3'b001);
        step(); idle();
        check("sub_valid", {31'd0, out_valid}, 32'd1);
        step(); check("and_valid", {31'd0, out_valid}, 32'd1);
        step();

        // INC 0x7FFF held by a 3-cycle stall, then exactly one commit.
        issue(4'd2, 16'h7FFF, 16'h0000);
        step(); idle(); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_no_valid", {31'd0, out_valid}, 32'd0);
            check("stall_ccr_hold", {29'd0, ccr}, 32'd1);
        end
        stall = 1'b0; expect_out(16'h8000, 4'd2, 3'b010);
        step();
        step();
        check("inc_once_valid", {31'd0, out_valid}, 32'd0);
        check("inc_once_ccr", {29'd0, ccr}, 32'd2);

        // MOV 1 (no flag update), SETC -> 100, DEC flushed with a squashed arrival.
        issue(4'd4, 16'h0001, 16'h0000); expect_out(16'h0001, 4'd4, 3'b010);
        step();
        issue(4'd11, 16'h0000, 16'h0000); expect_out(16'h0001, 4'd11, 3'b100);
        step();
        issue(4'd3, 16'h0001, 16'h0000);
        step();
        issue(4'd5, 16'h0003, 16'h0003); flush = 1'b1;
        step(); idle(); flush = 1'b0;
        check("flush_no_commit", {31'd0, out_valid}, 32'd0);
        check("flush_ccr", {29'd0, ccr}, 32'd4);
        issue(4'd4, 16'h0005, 16'h0000); expect_out(16'h0005, 4'd4, 3'b100);
        step(); idle();
        step();

        // Interrupt save, CLRC + ADD 0+0, then RTI restores 100.
        issue(4'd11, 16'h0000, 16'h0000); expect_out(16'h0005, 4'd11, 3'b100);
        step(); idle();
        step(); int_save = 1'b1;
        step(); int_save = 1'b0;
        issue(4'd12, 16'h0000, 16'h0000); expect_out(16'h0005, 4'd12, 3'b000);
        step();
        issue(4'd5, 16'h0000, 16'h0000); expect_out(16'h0000, 4'd5, 3'b001);
        step(); idle();
        step(); check("pre_rti_ccr", {29'd0, ccr}, 32'd1);
        rti_restore = 1'b1;
        step(); rti_restore = 1'b0;
        check("rti_ccr", {29'd0, ccr}, 32'd4);

        // RTI on the same edge as a committing SUB (which alone would give 000).
        issue(4'd6, 16'h0003, 16'h0001); expect_out(16'h0002, 4'd6, 3'b100);
        step(); idle(); rti_restore = 1'b1;
        step(); rti_restore = 1'b0;

        // Save + restore together swap CCR and shadow.
        issue(4'd5, 16'h0001, 16'h0001); expect_out(16'h0002, 4'd5, 3'b000);
        step(); idle();
        step(); int_save = 1'b1; rti_restore = 1'b1;
        step(); int_save = 1'b0; rti_restore = 1'b0;
        check("swap_ccr", {29'd0, ccr}, 32'd4);
        rti_restore = 1'b1;
        step(); rti_restore = 1'b0;
        check("swap_shadow", {29'd0, ccr}, 32'd0);

        // Jump clear of Z on the edge that commits a Z=1 result.
        issue(4'd5, 16'h0000, 16'h0000); expect_out(16'h0000, 4'd5, 3'b000);
        step(); idle(); flag_clr = 3'b001;
        step(); flag_clr = 3'b000;
        check("flag_clr_z", {29'd0, ccr}, 32'd0);

        // Reset mid-pipe: one result committed, another in EX, then async reset.
        issue(4'd5, 16'hFFFF, 16'h0002); expect_out(16'h0001, 4'd5, 3'b100);
        step();
        issue(4'd5, 16'h0004, 16'h0004);
        step(); idle();
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_reset_idle", {31'd0, out_valid}, 32'd0);
        end

        // Shadow was cleared by reset: SETC then RTI returns CCR to 000.
        issue(4'd11, 16'h0000, 16'h0000); expect_out(16'h0001, 4'd11, 3'b100);
        step(); idle();
        step(); rti_restore = 1'b1;
        step(); rti_restore = 1'b0;
        check("shadow_reset", {29'd0, ccr}, 32'd0);

        step(); step();
        check("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
